// File: rtl/count_ones_pkg.sv
// Shared types and helpers for the iterative population-count engine.
package count_ones_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Count width that holds every value 0..data_w without wrapping.
    function automatic int calc_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/count_ones.sv
// Iterative popcount: shift the word right one bit per clock until it is zero.
// Optional parity output enabled by defining COUNT_ONES_PARITY_EN.
module count_ones
    import count_ones_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = calc_cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ones
`ifdef COUNT_ONES_PARITY_EN
    ,
    output logic              parity
`endif
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  acc;
    logic              shreg_zero;

    assign shreg_zero = (shreg == '0);
    assign busy       = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (shreg_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg   <= '0;
            acc     <= '0;
            done    <= 1'b0;
            ones    <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg <= data;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    // Early exit once no set bits remain above the shift point.
                    if (shreg_zero) begin
                        done <= 1'b1;
                        ones <= acc;
                    end else begin
                        acc   <= acc + CNT_W'(shreg[0]);
                        shreg <= shreg >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COUNT_ONES_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            parity <= 1'b0;
        else if (state_q == RUN && shreg_zero)
            parity <= acc[0];
    end
`endif

endmodule

// File: tb/tb_count_ones.sv
// Directed bench for count_ones: latency, result, handshake and reset cases.
module tb_count_ones;

    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  ones;
`ifdef COUNT_ONES_PARITY_EN
    logic              parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    count_ones #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .ones  (ones)
`ifdef COUNT_ONES_PARITY_EN
        ,
        .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse, return cycles from accept edge to done (-1 on timeout).
    task automatic run_word(input logic [DATA_W-1:0] w, output int lat);
        data  = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL timeout word=%h: no done within 40 cycles", w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ones !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b ones=%0d want 0 0 0", busy, done, ones);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet cycle %0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_zero();
        int lat;
        run_word(16'h0000, lat);
        n_checks++;
        if (lat !== 1 || ones !== 5'd0) begin
            n_fail++;
            $display("FAIL zero_word: lat=%0d ones=%0d want 1 0", lat, ones);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy: busy=%b want 0 at done", busy);
        end
    endtask

    task automatic test_counts();
        int lat;
        run_word(16'h00B5, lat);
        n_checks++;
        if (lat !== 9 || ones !== 5'd5) begin
            n_fail++;
            $display("FAIL b5_word: lat=%0d ones=%0d want 9 5", lat, ones);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || ones !== 5'd5) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b ones=%0d want 0 5", done, ones);
        end
        run_word(16'hFFFF, lat);
        n_checks++;
        if (lat !== 17 || ones !== 5'd16) begin
            n_fail++;
            $display("FAIL ffff_word: lat=%0d ones=%0d want 17 16", lat, ones);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int lat;
        data  = 16'h8001;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_state: busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        tick();
        data  = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        for (int c = 4; c <= 40; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat !== 17 || ones !== 5'd2) begin
            n_fail++;
            $display("FAIL start_ignored: lat=%0d ones=%0d want 17 2", lat, ones);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_second_done cycle %0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    // Start presented only on the completion edge must be dropped.
    task automatic test_start_on_done();
        data  = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        data  = 16'h00FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ones !== 5'd2) begin
            n_fail++;
            $display("FAIL done_edge: done=%b busy=%b ones=%0d want 1 0 2", done, busy, ones);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_on_done_ignored cycle %0d: busy=%b done=%b want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        data  = 16'hF000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ones !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b ones=%0d want 0 0 0", busy, done, ones);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL aborted_done cycle %0d: done=%b want 0", i, done);
            end
        end
        run_word(16'h0007, lat);
        n_checks++;
        if (lat !== 4 || ones !== 5'd3) begin
            n_fail++;
            $display("FAIL after_reset: lat=%0d ones=%0d want 4 3", lat, ones);
        end
        tick();
    endtask

`ifdef COUNT_ONES_PARITY_EN
    task automatic test_parity();
        int lat;
        run_word(16'h0007, lat);
        n_checks++;
        if (parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_7: parity=%b want 1", parity);
        end
        tick();
        run_word(16'h0003, lat);
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_3: parity=%b want 0", parity);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_counts();
        test_start_ignored();
        test_start_on_done();
        test_reset_mid_run();
`ifdef COUNT_ONES_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
